debug_mem_loader: RTL
=====================

Name: debug_mem_loader

Overview:
- Host-side programming/debug front end sitting directly upstream of the RV32 core's debug ports.
- Consumes a byte stream from a UART receiver and assembles word commands. Drives the core's instruction-RAM and data-RAM second ports (A2/WD2/WE2), reads back RD2, and returns bytes to a UART transmitter.
- Owns the core reset, so software can be loaded while the pipeline is held and then released.

Parameters:
- RD_LATENCY, 1, cycles from A2 valid to RD2 valid on the RAM second port (1..3).
- ACK_BYTE, 8'hA5, byte returned after every completed write or run/halt command.
- NAK_BYTE, 8'hEE, byte returned for an unknown command code.

Ports:
- clk  in  1  core clock (same clock as the CPU)
- rst  in  1  asynchronous, active-high reset
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts rx_data this cycle
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts tx_data this cycle
- cpu_rst  out  1  reset to the core, 1 = core held
- inst_a2  out  32  instruction RAM port-2 byte address
- inst_wd2  out  32  instruction RAM port-2 write data
- inst_we2  out  4  instruction RAM port-2 byte enables
- inst_rd2  in  32  instruction RAM port-2 read data
- data_a2  out  32  data RAM port-2 byte address
- data_wd2  out  32  data RAM port-2 write data
- data_we2  out  4  data RAM port-2 byte enables
- data_rd2  in  32  data RAM port-2 read data
- busy  out  1  command in progress (state != IDLE)
- err  out  1  sticky: unknown command seen; cleared only by rst

Behaviour:
- Reset values:
  - cpu_rst=1; rx_ready=0; tx_valid=0; tx_data=0; busy=0; err=0.
  - All a2/wd2 outputs = 0; all we2 outputs = 0.
- Handshakes: a byte transfers on rx_valid&rx_ready, and on tx_valid&tx_ready. tx_data is held stable while tx_valid=1 and tx_ready=0.
- Command byte:
  - 8'h01 = write inst
  - 8'h03 = write data
  - 8'h00 = read inst
  - 8'h02 = read data
  - 8'h40 = halt (cpu_rst<=1)
  - 8'h80 = run (cpu_rst<=0)
  - anything else = NAK.
- Multi-byte fields: address = 4 bytes, little-endian. Write data = 4 bytes, little-endian. Address bits[1:0] are forced to 0 on the a2 outputs.
- FSM states:
  - IDLE: rx_ready=1.
    - 01/03 -> ADDR.
    - 00/02 -> ADDR.
    - 40/80 -> update cpu_rst, then RESP with 1 byte = ACK_BYTE.
    - unknown -> set err, then RESP with 1 byte = NAK_BYTE.
  - ADDR: rx_ready=1. A 2-bit counter shifts in 4 bytes. After the 4th byte: write -> DATA; read -> RD_REQ.
  - DATA: rx_ready=1. 4 bytes shifted in, then -> WR.
  - WR: exactly one cycle.
    - The selected port's a2/wd2 are driven and its we2=4'hF; the other port's we2=0.
    - -> RESP with 1 byte ACK_BYTE.
  - RD_REQ: selected a2 driven, we2=0. Wait RD_LATENCY cycles (counter), then capture the selected rd2 into a 32-bit shift register -> RESP with 4 bytes, LSB first.
  - RESP: tx_valid=1, rx_ready=0. Each tx handshake shifts out the next byte. After the last byte -> IDLE.
- we2 is 0 in every state except WR. a2/wd2 hold their last values outside WR/RD_REQ.
- Writes and reads are permitted while cpu_rst=0. Collision with core accesses is the host's responsibility; the loader does not check for it.
- rx_valid while rx_ready=0: the byte is not consumed; the upstream holds it.
- tx_ready held 0: the FSM stays in RESP indefinitely. There is no timeout.
- rst asserted mid-command: immediate return to IDLE, partial fields discarded, cpu_rst=1.
- Throughput: a write command is 9 rx bytes, then 1 WR cycle, then the ACK.

Decomposition:
- Shared package holds:
  - command codes (CMD_WR_INST, CMD_WR_DATA, CMD_RD_INST, CMD_RD_DATA, CMD_HALT, CMD_RUN);
  - the FSM state encoding (IDLE, ADDR, DATA, WR, RD_REQ, RESP);
  - ACK/NAK defaults.
- One natural sub-module: loader_tx_shifter. It holds a 32-bit word, sends 1 or 4 bytes under the tx valid/ready handshake, and signals done.

Test Plan:
- Reset -> cpu_rst=1, all we2=0, err=0, tx_valid=0. Send 0x80 -> cpu_rst=0, tx byte 0xA5.
- Send 01, 10 00 00 00, 13 05 00 00 -> one cycle with inst_a2=32'h10, inst_wd2=32'h00000513, inst_we2=4'hF, data_we2=0; then tx 0xA5.
- Preload data RAM word 0x20 = 32'hDEADBEEF; send 02, 23 00 00 00 -> data_a2=32'h20 (low bits masked), no we2 pulse, tx bytes EF BE AD DE in order.
- Send 0x7F -> tx 0xEE, err=1 and remains 1 across subsequent valid commands.
- Read with tx_ready=0 for 10 cycles mid-response -> tx_data stable, rx_ready=0; bytes resume in order once tx_ready=1.
- Assert rst after 2 address bytes of a write -> IDLE, no we2 pulse; a following full write completes correctly.

Source files
------------

// File: rtl/debug_mem_loader_pkg.sv
// +--------------------------------------------------------------------+
// | debug_mem_loader_pkg                                               |
// | Command codes, FSM encoding and response defaults for the loader.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package debug_mem_loader_pkg;

  localparam logic [7:0] CMD_RD_INST = 8'h00;
  localparam logic [7:0] CMD_WR_INST = 8'h01;
  localparam logic [7:0] CMD_RD_DATA = 8'h02;
  localparam logic [7:0] CMD_WR_DATA = 8'h03;
  localparam logic [7:0] CMD_HALT    = 8'h40;
  localparam logic [7:0] CMD_RUN     = 8'h80;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ADDR   = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_WR     = 3'd3;
  localparam logic [2:0] ST_RD_REQ = 3'd4;
  localparam logic [2:0] ST_RESP   = 3'd5;

  localparam logic [7:0] ACK_DEFAULT = 8'hA5;
  localparam logic [7:0] NAK_DEFAULT = 8'hEE;

endpackage

`default_nettype wire

// File: rtl/debug_mem_loader_tx_shifter.sv
// +--------------------------------------------------------------------+
// | loader_tx_shifter                                                  |
// | Sends 1 or 4 bytes of a word, LSB first, under tx valid/ready.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module loader_tx_shifter (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld,
  input  logic [31:0] ld_word,
  input  logic        ld_four,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        done
);

  logic [31:0] word_q, word_d;
  logic [1:0]  left_q, left_d;
  logic        valid_q, valid_d;
  logic        w_fire;

  assign w_fire   = valid_q & tx_ready;
  assign done     = w_fire & (left_q == 2'd0);
  assign tx_data  = word_q[7:0];
  assign tx_valid = valid_q;

  always_comb begin
    word_d  = word_q;
    left_d  = left_q;
    valid_d = valid_q;
    if (ld) begin
      word_d  = ld_word;
      left_d  = ld_four ? 2'd3 : 2'd0;
      valid_d = 1'b1;
    end else if (w_fire) begin
      word_d = {8'h00, word_q[31:8]};
      left_d = left_q - 2'd1;
      if (left_q == 2'd0) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q  <= 32'h0;
      left_q  <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      left_q  <= left_d;
      valid_q <= valid_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/debug_mem_loader.sv
// +--------------------------------------------------------------------+
// | debug_mem_loader                                                   |
// | UART-byte command front end for the core's RAM debug ports/reset.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module debug_mem_loader
  import debug_mem_loader_pkg::*;
#(
  parameter int         RD_LATENCY = 1,
  parameter logic [7:0] ACK_BYTE   = ACK_DEFAULT,
  parameter logic [7:0] NAK_BYTE   = NAK_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        cpu_rst,
  output logic [31:0] inst_a2,
  output logic [31:0] inst_wd2,
  output logic [3:0]  inst_we2,
  input  logic [31:0] inst_rd2,
  output logic [31:0] data_a2,
  output logic [31:0] data_wd2,
  output logic [3:0]  data_we2,
  input  logic [31:0] data_rd2,
  output logic        busy,
  output logic        err
);

  localparam logic [1:0] LAT_LAST = 2'(RD_LATENCY);

  logic [2:0]  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  lat_q, lat_d;
  logic        is_wr_q, is_wr_d;
  logic        is_data_q, is_data_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        cpu_rst_q, cpu_rst_d;
  logic        err_q, err_d;
  logic        rx_ready_q, rx_ready_d;
  logic [31:0] inst_a2_q, inst_a2_d, inst_wd2_q, inst_wd2_d;
  logic [31:0] data_a2_q, data_a2_d, data_wd2_q, data_wd2_d;
  logic [3:0]  inst_we2_q, inst_we2_d, data_we2_q, data_we2_d;

  logic        w_rx_fire;
  logic [31:0] w_addr_shift;
  logic [31:0] w_data_shift;
  logic        w_ld;
  logic [31:0] w_ld_word;
  logic        w_ld_four;
  logic        w_tx_done;

  assign w_rx_fire    = rx_valid & rx_ready_q;
  assign w_addr_shift = {rx_data, addr_q[31:8]};
  assign w_data_shift = {rx_data, wdata_q[31:8]};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lat_d      = lat_q;
    is_wr_d    = is_wr_q;
    is_data_d  = is_data_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cpu_rst_d  = cpu_rst_q;
    err_d      = err_q;
    inst_a2_d  = inst_a2_q;
    inst_wd2_d = inst_wd2_q;
    data_a2_d  = data_a2_q;
    data_wd2_d = data_wd2_q;
    inst_we2_d = 4'h0;
    data_we2_d = 4'h0;
    w_ld       = 1'b0;
    w_ld_word  = {24'h0, ACK_BYTE};
    w_ld_four  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (w_rx_fire) begin
          cnt_d     = 2'd0;
          is_wr_d   = (rx_data == CMD_WR_INST) || (rx_data == CMD_WR_DATA);
          is_data_d = (rx_data == CMD_WR_DATA) || (rx_data == CMD_RD_DATA);
          case (rx_data)
            CMD_WR_INST, CMD_WR_DATA, CMD_RD_INST, CMD_RD_DATA: begin
              state_d = ST_ADDR;
            end
            CMD_HALT, CMD_RUN: begin
              cpu_rst_d = (rx_data == CMD_HALT);
              w_ld      = 1'b1;
              state_d   = ST_RESP;
            end
            default: begin
              err_d     = 1'b1;
              w_ld      = 1'b1;
              w_ld_word = {24'h0, NAK_BYTE};
              state_d   = ST_RESP;
            end
          endcase
        end
      end
      ST_ADDR: begin
        if (w_rx_fire) begin
          addr_d = w_addr_shift;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (is_wr_q) begin
              state_d = ST_DATA;
            end else begin
              state_d = ST_RD_REQ;
              lat_d   = 2'd0;
              if (is_data_q) data_a2_d = {w_addr_shift[31:2], 2'b00};
              else           inst_a2_d = {w_addr_shift[31:2], 2'b00};
            end
          end
        end
      end
      ST_DATA: begin
        // Outputs are registered, so the strobe is loaded here to be live during WR.
        if (w_rx_fire) begin
          wdata_d = w_data_shift;
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = ST_WR;
            if (is_data_q) begin
              data_a2_d  = {addr_q[31:2], 2'b00};
              data_wd2_d = w_data_shift;
              data_we2_d = 4'hF;
            end else begin
              inst_a2_d  = {addr_q[31:2], 2'b00};
              inst_wd2_d = w_data_shift;
              inst_we2_d = 4'hF;
            end
          end
        end
      end
      ST_WR: begin
        w_ld    = 1'b1;
        state_d = ST_RESP;
      end
      ST_RD_REQ: begin
        if (lat_q == LAT_LAST) begin
          w_ld      = 1'b1;
          w_ld_four = 1'b1;
          w_ld_word = is_data_q ? data_rd2 : inst_rd2;
          state_d   = ST_RESP;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      ST_RESP: begin
        if (w_tx_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    rx_ready_d = (state_d == ST_IDLE) || (state_d == ST_ADDR) || (state_d == ST_DATA);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 2'd0;
      lat_q      <= 2'd0;
      is_wr_q    <= 1'b0;
      is_data_q  <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      cpu_rst_q  <= 1'b1;
      err_q      <= 1'b0;
      rx_ready_q <= 1'b0;
      inst_a2_q  <= 32'h0;
      inst_wd2_q <= 32'h0;
      inst_we2_q <= 4'h0;
      data_a2_q  <= 32'h0;
      data_wd2_q <= 32'h0;
      data_we2_q <= 4'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lat_q      <= lat_d;
      is_wr_q    <= is_wr_d;
      is_data_q  <= is_data_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cpu_rst_q  <= cpu_rst_d;
      err_q      <= err_d;
      rx_ready_q <= rx_ready_d;
      inst_a2_q  <= inst_a2_d;
      inst_wd2_q <= inst_wd2_d;
      inst_we2_q <= inst_we2_d;
      data_a2_q  <= data_a2_d;
      data_wd2_q <= data_wd2_d;
      data_we2_q <= data_we2_d;
    end
  end

  loader_tx_shifter u_tx (
    .clk      (clk),
    .rst      (rst),
    .ld       (w_ld),
    .ld_word  (w_ld_word),
    .ld_four  (w_ld_four),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .done     (w_tx_done)
  );

  assign rx_ready = rx_ready_q;
  assign cpu_rst  = cpu_rst_q;
  assign err      = err_q;
  assign busy     = (state_q != ST_IDLE);
  assign inst_a2  = inst_a2_q;
  assign inst_wd2 = inst_wd2_q;
  assign inst_we2 = inst_we2_q;
  assign data_a2  = data_a2_q;
  assign data_wd2 = data_wd2_q;
  assign data_we2 = data_we2_q;

endmodule

`default_nettype wire
